cook_timer: RTL



---
 rtl/cook_timer.sv | 112 +++++++++++
 1 files changed

// File: rtl/cook_timer.sv
// rtl/cook_timer.sv - BCD MM:SS cook-time countdown driven by magnetron state
//
// Ports:
//   clk         system clock, all state on rising edge
//   resetn      asynchronous active-low reset
//   clearn      synchronous active-low clear of cook time and prescaler
//   digit_valid one-cycle keypad strobe
//   digit       keypad digit (BCD 0-9; larger values are ignored)
//   mag_on      magnetron state; time counts down while high
//   min_tens, min_ones, sec_tens, sec_ones  BCD display digits
//   timer_done  all four digits zero (combinational)
//   done_pulse  one-cycle pulse after a tick takes 00:01 to 00:00
//   running     mag_on with nonzero time (combinational)
module cook_timer #(
    parameter int TICK_DIV = 100,
    parameter int PRE_W    = 7
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       clearn,
    input  logic       digit_valid,
    input  logic [3:0] digit,
    input  logic       mag_on,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       timer_done,
    output logic       done_pulse,
    output logic       running
);

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    logic [PRE_W-1:0] pre;
    logic             digit_accept;
    logic             tick;
    logic             last_second;
    logic [3:0]       so_dec;
    logic [3:0]       st_dec;
    logic [3:0]       mo_dec;
    logic [3:0]       mt_dec;
    logic             b_so;
    logic             b_st;
    logic             b_mo;

    assign timer_done   = (min_tens == 4'd0) && (min_ones == 4'd0) &&
                          (sec_tens == 4'd0) && (sec_ones == 4'd0);
    assign running      = mag_on & ~timer_done;
    assign digit_accept = digit_valid && (digit <= 4'd9) && !mag_on;
    // The prescaler only advances while running, so a stopped or empty
    // timer never generates a tick.
    assign tick         = running && (pre == PRE_LAST);
    assign last_second  = (min_tens == 4'd0) && (min_ones == 4'd0) &&
                          (sec_tens == 4'd0) && (sec_ones == 4'd1);

    // Digit-wise BCD decrement with borrow. Seconds above 59 are left as
    // entered; only a borrow into sec_tens wraps it to 5.
    always_comb begin
        b_so   = (sec_ones == 4'd0);
        so_dec = b_so ? 4'd9 : sec_ones - 4'd1;
        b_st   = b_so && (sec_tens == 4'd0);
        st_dec = sec_tens;
        if (b_so) begin
            st_dec = (sec_tens == 4'd0) ? 4'd5 : sec_tens - 4'd1;
        end
        b_mo   = b_st && (min_ones == 4'd0);
        mo_dec = min_ones;
        if (b_st) begin
            mo_dec = (min_ones == 4'd0) ? 4'd9 : min_ones - 4'd1;
        end
        mt_dec = b_mo ? min_tens - 4'd1 : min_tens;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            min_tens   <= 4'd0;
            min_ones   <= 4'd0;
            sec_tens   <= 4'd0;
            sec_ones   <= 4'd0;
            pre        <= '0;
            done_pulse <= 1'b0;
        end else begin
            done_pulse <= 1'b0;
            if (!clearn) begin
                min_tens <= 4'd0;
                min_ones <= 4'd0;
                sec_tens <= 4'd0;
                sec_ones <= 4'd0;
                pre      <= '0;
            end else if (digit_accept) begin
                min_tens <= min_ones;
                min_ones <= sec_tens;
                sec_tens <= sec_ones;
                sec_ones <= digit;
                pre      <= '0;
            end else if (running) begin
                if (tick) begin
                    pre        <= '0;
                    min_tens   <= mt_dec;
                    min_ones   <= mo_dec;
                    sec_tens   <= st_dec;
                    sec_ones   <= so_dec;
                    done_pulse <= last_second;
                end else begin
                    pre <= pre + PRE_W'(1);
                end
            end
        end
    end

endmodule
